// File: rtl/alu_op_sequencer_if.sv
// Request, ALU and result signal bundle for alu_op_sequencer.
// The sequencer connects through the slave modport; its environment uses master.
interface alu_op_sequencer_if #(
   parameter int W   = 4,
   parameter int OPW = 4
);
   logic           in_valid;
   logic           in_ready;
   logic [OPW-1:0] in_op;
   logic [W-1:0]   in_a;
   logic [W-1:0]   in_b;
   logic           in_cin;
   logic           in_chain;

   logic [OPW-1:0] alu_m;
   logic [W-1:0]   alu_a;
   logic [W-1:0]   alu_b;
   logic           alu_cin;
   logic [W-1:0]   alu_r;
   logic           alu_of;

   logic           res_valid;
   logic           res_ready;
   logic [W-1:0]   res_data;
   logic           res_of;

   modport master (
      output in_valid, in_op, in_a, in_b, in_cin, in_chain,
      output alu_r, alu_of, res_ready,
      input  in_ready, alu_m, alu_a, alu_b, alu_cin,
      input  res_valid, res_data, res_of
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_cin, in_chain,
      input  alu_r, alu_of, res_ready,
      output in_ready, alu_m, alu_a, alu_b, alu_cin,
      output res_valid, res_data, res_of
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue stage for the accumulator ALU: queues requests, issues one at a time,
// waits out the ALU latency and holds each result until the consumer takes it.
module alu_op_sequencer #(
   parameter int W       = 4,
   parameter int OPW     = 4,
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic                 Clk,
   input  logic                 Reset,
   alu_op_sequencer_if.slave    bus,
   output logic [7:0]           of_count,
   output logic                 busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = OPW + 2 * W + 2;
   localparam int LW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
   localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
   localparam logic [LW-1:0] LAT_C   = LW'(ALU_LAT);
   localparam logic [LW-1:0] ONE_C   = LW'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t         state, state_nxt;
   logic [EW-1:0]  fifo_mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic           fifo_empty;
   logic           push, pop;
   logic           res_pop;
   logic           issue_load, capture;
   logic [LW-1:0]  wait_cnt;
   logic [W-1:0]   last_result;

   logic [OPW-1:0] head_op;
   logic [W-1:0]   head_a, head_b;
   logic           head_cin, head_chain;

   assign fifo_empty   = (count == '0);
   assign bus.in_ready = (count < DEPTH_C);
   assign push         = bus.in_valid & bus.in_ready;
   assign pop          = issue_load;
   assign res_pop      = bus.res_valid & bus.res_ready;
   assign {head_op, head_a, head_b, head_cin, head_chain} = fifo_mem[rd_ptr];

   // Request FIFO: storage carries no reset, only pointers and count do
   always_ff @(posedge Clk) begin
      if (push)
         fifo_mem[wr_ptr] <= {bus.in_op, bus.in_a, bus.in_b, bus.in_cin, bus.in_chain};
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (!fifo_empty) state_nxt = ISSUE;
         ISSUE: state_nxt = WAIT;
         WAIT:  if (wait_cnt == ONE_C) state_nxt = HOLD;
         HOLD:  if (res_pop) state_nxt = fifo_empty ? IDLE : ISSUE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      issue_load = 1'b0;
      capture    = 1'b0;
      busy       = (state != IDLE) || !fifo_empty;
      case (state)
         IDLE:  issue_load = !fifo_empty;
         WAIT:  capture    = (wait_cnt == ONE_C);
         HOLD:  issue_load = res_pop && !fifo_empty;
         default: ;
      endcase
   end

   // Issue registers toward the ALU; chained ops take A from the last capture
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         bus.alu_m   <= '0;
         bus.alu_a   <= '0;
         bus.alu_b   <= '0;
         bus.alu_cin <= 1'b0;
      end else if (issue_load) begin
         bus.alu_m   <= head_op;
         bus.alu_a   <= head_chain ? last_result : head_a;
         bus.alu_b   <= head_b;
         bus.alu_cin <= head_cin;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)              wait_cnt <= '0;
      else if (state == ISSUE) wait_cnt <= LAT_C;
      else if (state == WAIT)  wait_cnt <= wait_cnt - 1'b1;
   end

   // Result capture and hold
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         bus.res_valid <= 1'b0;
         bus.res_data  <= '0;
         bus.res_of    <= 1'b0;
         last_result   <= '0;
         of_count      <= '0;
      end else begin
         if (capture) begin
            bus.res_valid <= 1'b1;
            bus.res_data  <= bus.alu_r;
            bus.res_of    <= bus.alu_of;
            last_result   <= bus.alu_r;
            if (bus.alu_of) of_count <= sat_inc(of_count);
         end else if (res_pop) begin
            bus.res_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an adder stub ALU ({of,r} = a + b + cin, one cycle).
module tb_alu_op_sequencer;
   logic       Clk = 1'b0;
   logic       Reset;
   logic [7:0] of_count;
   logic       busy;
   int         checks = 0;
   int         failures = 0;
   logic [3:0] exp_t2 [5];

   alu_op_sequencer_if #(.W(4), .OPW(4)) bus ();

   alu_op_sequencer #(.W(4), .OPW(4), .DEPTH(4), .ALU_LAT(1)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .bus      (bus.slave),
      .of_count (of_count),
      .busy     (busy)
   );

   always #5 Clk = ~Clk;

   always_ff @(posedge Clk)
      {bus.alu_of, bus.alu_r} <= {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'b0, bus.alu_cin};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic chain);
      int n = 0;
      bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_chain = chain;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (!bus.in_ready) begin
         check("push_timeout", {31'b0, bus.in_ready}, 32'd1);
         bus.in_valid = 1'b0;
      end else begin
         @(posedge Clk);
         @(negedge Clk);
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic get_result(input logic [3:0] exp_d, input logic exp_of, input string tag);
      int n = 0;
      while (!bus.res_valid && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (!bus.res_valid) begin
         check({tag, "_timeout"}, {31'b0, bus.res_valid}, 32'd1);
      end else begin
         check({tag, "_data"}, {28'b0, bus.res_data}, {28'b0, exp_d});
         check({tag, "_of"}, {31'b0, bus.res_of}, {31'b0, exp_of});
         bus.res_ready = 1'b1;
         @(posedge Clk);
         @(negedge Clk);
         bus.res_ready = 1'b0;
      end
   endtask

   initial begin
      exp_t2[0] = 4'h3; exp_t2[1] = 4'h4; exp_t2[2] = 4'h5; exp_t2[3] = 4'h6; exp_t2[4] = 4'h7;
      Reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
      bus.in_cin = 1'b0; bus.in_chain = 1'b0; bus.res_ready = 1'b0;
      repeat (3) @(negedge Clk);
      check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
      check("rst_alu_a", {28'b0, bus.alu_a}, 32'd0);
      check("rst_of_count", {24'b0, of_count}, 32'd0);
      Reset = 1'b0;
      @(negedge Clk);

      // Test 1: single op with overflow, latency of three edges
      push(4'h0, 4'hF, 4'h1, 1'b0, 1'b0);
      check("t1_pre_issue_alu_a", {28'b0, bus.alu_a}, 32'd0);
      check("t1_busy", {31'b0, busy}, 32'd1);
      @(negedge Clk);
      check("t1_issue_alu_a", {28'b0, bus.alu_a}, 32'hF);
      check("t1_issue_alu_b", {28'b0, bus.alu_b}, 32'h1);
      check("t1_issue_alu_m", {28'b0, bus.alu_m}, 32'h0);
      check("t1_issue_res_valid", {31'b0, bus.res_valid}, 32'd0);
      @(negedge Clk);
      check("t1_wait_res_valid", {31'b0, bus.res_valid}, 32'd0);
      @(negedge Clk);
      check("t1_res_valid", {31'b0, bus.res_valid}, 32'd1);
      check("t1_res_data", {28'b0, bus.res_data}, 32'h0);
      check("t1_res_of", {31'b0, bus.res_of}, 32'd1);
      check("t1_of_count", {24'b0, of_count}, 32'd1);
      bus.res_ready = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      bus.res_ready = 1'b0;
      check("t1_pop_res_valid", {31'b0, bus.res_valid}, 32'd0);
      check("t1_idle_busy", {31'b0, busy}, 32'd0);

      // Test 2: back-pressure fills the FIFO, then ordered drain
      for (int i = 0; i < 5; i++) push(4'h1, 4'(i + 1), 4'h2, 1'b0, 1'b0);
      check("t2_full_in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("t2_full_busy", {31'b0, busy}, 32'd1);
      for (int i = 0; i < 5; i++) get_result(exp_t2[i], 1'b0, "t2");
      check("t2_drained_in_ready", {31'b0, bus.in_ready}, 32'd1);

      // Test 3: chaining the previous result into operand A
      push(4'h0, 4'h7, 4'h1, 1'b0, 1'b0);
      get_result(4'h8, 1'b0, "t3_first");
      push(4'h0, 4'h0, 4'h2, 1'b0, 1'b1);
      @(negedge Clk);
      check("t3_chain_alu_a", {28'b0, bus.alu_a}, 32'h8);
      check("t3_chain_alu_b", {28'b0, bus.alu_b}, 32'h2);
      get_result(4'hA, 1'b0, "t3_chain");

      // Test 4: held result stays stable and nothing new issues
      push(4'h2, 4'h2, 4'h3, 1'b0, 1'b0);
      push(4'h2, 4'h4, 4'h4, 1'b0, 1'b0);
      push(4'h2, 4'h9, 4'h6, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         check("t4_res_valid", {31'b0, bus.res_valid}, 32'd1);
         check("t4_res_data", {28'b0, bus.res_data}, 32'h5);
         check("t4_alu_a", {28'b0, bus.alu_a}, 32'h2);
         check("t4_alu_b", {28'b0, bus.alu_b}, 32'h3);
         check("t4_busy", {31'b0, busy}, 32'd1);
      end
      get_result(4'h5, 1'b0, "t4_a");
      get_result(4'h8, 1'b0, "t4_b");
      get_result(4'hF, 1'b0, "t4_c");

      // Test 5: asynchronous reset while waiting on the ALU
      push(4'h0, 4'h3, 4'h4, 1'b0, 1'b0);
      @(negedge Clk);
      @(negedge Clk);
      check("t5_pre_alu_a", {28'b0, bus.alu_a}, 32'h3);
      #1 Reset = 1'b1;
      #1;
      check("t5_rst_alu_a", {28'b0, bus.alu_a}, 32'd0);
      check("t5_rst_alu_b", {28'b0, bus.alu_b}, 32'd0);
      check("t5_rst_res_data", {28'b0, bus.res_data}, 32'd0);
      check("t5_rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
      check("t5_rst_of_count", {24'b0, of_count}, 32'd0);
      check("t5_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check("t5_rst_busy", {31'b0, busy}, 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check("t5_no_capture", {31'b0, bus.res_valid}, 32'd0);
      push(4'h0, 4'hE, 4'h5, 1'b0, 1'b1);
      get_result(4'h5, 1'b0, "t5_chain_after_rst");
      push(4'h0, 4'hA, 4'h5, 1'b0, 1'b0);
      get_result(4'hF, 1'b0, "t5_after_rst");

      // Test 6: overflow counter saturation
      for (int i = 0; i < 260; i++) begin
         push(4'h0, 4'hF, 4'h1, 1'b0, 1'b0);
         get_result(4'h0, 1'b1, "t6");
         if (i == 253) check("t6_of_count_254", {24'b0, of_count}, 32'd254);
      end
      check("t6_of_count_sat", {24'b0, of_count}, 32'd255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
